// File: rtl/prog_lut_seq.sv
// Programmable N_IN-input Boolean function: a registered truth-table lookup whose
// table is reloaded through a serial port into a shadow and committed atomically.
module prog_lut_seq #(
   parameter int unsigned  N_IN  = 3,
   localparam int unsigned DEPTH = 2 ** N_IN,
   parameter logic [DEPTH-1:0] INIT = DEPTH'(8'hA2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [N_IN-1:0]  in_vec,
   output logic             out_valid,
   output logic             y,
   input  logic             cfg_start,
   input  logic             cfg_abort,
   input  logic             cfg_valid,
   input  logic             cfg_bit,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic [DEPTH-1:0] table_q
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DEPTH-1:0] shadow_q, shadow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             commit_c;

   // Config FSM state, shadow and counter; ready/done are registered decodes of the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         cnt_q     <= '0;
         cfg_ready <= 1'b0;
         cfg_done  <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         cnt_q     <= cnt_d;
         cfg_ready <= (state_d == SHIFT);
         cfg_done  <= (state_d == COMMIT);
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      commit_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d  = SHIFT;
               shadow_d = '0;
               cnt_d    = '0;
            end
         end
         SHIFT: begin
            // Abort beats restart beats a bit accept; a restart drops that cycle's bit
            if (cfg_abort) begin
               state_d  = IDLE;
               shadow_d = '0;
               cnt_d    = '0;
            end else if (cfg_start) begin
               shadow_d = '0;
               cnt_d    = '0;
            end else if (cfg_valid) begin
               shadow_d = {shadow_q[DEPTH-2:0], cfg_bit};
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == CW'(DEPTH - 1)) begin
                  state_d = COMMIT;
               end
            end
         end
         COMMIT: begin
            commit_c = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Lookup reads the pre-edge table, so a commit-cycle lookup still sees the old function
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         table_q   <= INIT;
         y         <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y <= table_q[in_vec];
         end
         if (commit_c) begin
            table_q <= shadow_q;
         end
      end
   end

endmodule

// File: tb/tb_prog_lut_seq.sv
// Directed bench for prog_lut_seq: table-driven lookup vectors plus hand-written
// load, collision, abort/restart and async-reset sequences.
module tb_prog_lut_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] in_vec;
   logic       out_valid;
   logic       y;
   logic       cfg_start;
   logic       cfg_abort;
   logic       cfg_valid;
   logic       cfg_bit;
   logic       cfg_ready;
   logic       cfg_done;
   logic [7:0] table_q;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       iv;
      logic [2:0] vec;
      logic       ev;
      logic       ey;
   } vec_t;

   vec_t vecs[$];

   prog_lut_seq #(.N_IN(3), .INIT(8'hA2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .y         (y),
      .cfg_start (cfg_start),
      .cfg_abort (cfg_abort),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_ready (cfg_ready),
      .cfg_done  (cfg_done),
      .table_q   (table_q)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Shift the top n bits of v MSB-first; optional idle gaps after bits 5 and 2
   task automatic shift_bits(input logic [7:0] v, input int n, input bit gaps);
      for (int i = 7; i >= 8 - n; i--) begin
         cfg_valid = 1'b1;
         cfg_bit   = v[i];
         tick();
         if (i == 0) begin
            chk("ready_after_last", 32'(cfg_ready), 0);
            chk("done_pulse", 32'(cfg_done), 1);
         end else begin
            chk("ready_during_load", 32'(cfg_ready), 1);
            chk("no_early_done", 32'(cfg_done), 0);
         end
         if (gaps && (i == 5 || i == 2)) begin
            cfg_valid = 1'b0;
            tick();
            chk("ready_in_gap", 32'(cfg_ready), 1);
         end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic start_load();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("ready_after_start", 32'(cfg_ready), 1);
   endtask

   task automatic eval(input logic [2:0] v, input logic ey, input string name);
      in_valid = 1'b1;
      in_vec   = v;
      tick();
      in_valid = 1'b0;
      chk(name, 32'(y), 32'(ey));
   endtask

   initial begin
      logic [7:0] init_v;
      init_v    = 8'hA2;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = '0;
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      cfg_valid = 1'b0;
      cfg_bit   = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      chk("rst_y", 32'(y), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_cfg_ready", 32'(cfg_ready), 0);
      chk("rst_cfg_done", 32'(cfg_done), 0);
      chk("rst_table", 32'(table_q), 32'h A2);

      // Reset sweep with in_valid held, then ten idle cycles holding y
      for (int k = 0; k < 8; k++) vecs.push_back('{1'b1, 3'(k), 1'b1, init_v[k]});
      for (int k = 0; k < 10; k++) vecs.push_back('{1'b0, 3'(k % 8), 1'b0, 1'b1});
      foreach (vecs[i]) begin
         in_valid = vecs[i].iv;
         in_vec   = vecs[i].vec;
         tick();
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].ey));
      end
      in_valid = 1'b0;

      // cfg_valid pulses in IDLE are ignored
      for (int k = 0; k < 3; k++) begin
         cfg_valid = 1'b1;
         cfg_bit   = 1'b1;
         tick();
         cfg_valid = 1'b0;
         tick();
      end
      chk("idle_ready", 32'(cfg_ready), 0);
      chk("idle_table", 32'(table_q), 32'h A2);

      // Abort after 4 bits
      start_load();
      shift_bits(8'h5A, 4, 1'b0);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      chk("abort_ready", 32'(cfg_ready), 0);
      chk("abort_done", 32'(cfg_done), 0);
      repeat (3) tick();
      chk("abort_done_later", 32'(cfg_done), 0);
      chk("abort_table", 32'(table_q), 32'h A2);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      chk("abort_idle_noop", 32'(table_q), 32'h A2);

      // Load 8'h69 with gaps; lookup collides with the COMMIT cycle
      start_load();
      shift_bits(8'h69, 8, 1'b1);
      cfg_start = 1'b1;
      cfg_abort = 1'b1;
      eval(3'd1, 1'b1, "collision_old_table");
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      chk("commit_done_clear", 32'(cfg_done), 0);
      chk("commit_ready", 32'(cfg_ready), 0);
      chk("table_69", 32'(table_q), 32'h69);
      eval(3'd1, 1'b0, "new_table_vec1");
      eval(3'd3, 1'b1, "new_table_vec3");
      eval(3'd6, 1'b1, "new_table_vec6");

      // Restart after 5 bits; the bit presented with cfg_start is dropped
      start_load();
      shift_bits(8'h00, 5, 1'b0);
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      chk("restart_ready", 32'(cfg_ready), 1);
      shift_bits(8'hFF, 8, 1'b0);
      tick();
      chk("table_ff", 32'(table_q), 32'h FF);
      eval(3'd0, 1'b1, "ff_vec0");

      // Async reset mid-clock after 6 bits, with y and out_valid driven high
      start_load();
      in_valid = 1'b1;
      in_vec   = 3'd7;
      shift_bits(8'h00, 6, 1'b0);
      chk("pre_reset_y", 32'(y), 1);
      chk("pre_reset_out_valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_y", 32'(y), 0);
      chk("areset_out_valid", 32'(out_valid), 0);
      chk("areset_ready", 32'(cfg_ready), 0);
      chk("areset_done", 32'(cfg_done), 0);
      chk("areset_table", 32'(table_q), 32'h A2);
      in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      chk("post_reset_table", 32'(table_q), 32'h A2);

      // Full load of 8'h00 after reset
      start_load();
      shift_bits(8'h00, 8, 1'b0);
      tick();
      chk("table_00", 32'(table_q), 32'h00);
      eval(3'd7, 1'b0, "zero_vec7");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prog_lut_seq.md
Name: prog_lut_seq

Overview:
Programmable N_IN-input Boolean function unit, the parametrised successor of the team's fixed 3-input truth-table blocks.
- Evaluation path: registered table lookup with a valid strobe.
- Reprogramming: the truth table is reloaded at run time through a serial configuration port, into a shadow register that is committed atomically.
- Used in lab datapaths wherever a switchable combinational function is needed without resynthesis.

Parameters:
N_IN, 3, number of function inputs (1..6).
DEPTH, 2**N_IN, truth-table entries (derived; not to be overridden).
INIT, 8'hA2 (DEPTH bits), reset truth table; bit k = output for input vector k.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  evaluate in_vec this cycle
in_vec  input  N_IN  function input vector; MSB is the leftmost variable
out_valid  output  1  y updated this cycle
y  output  1  registered function output
cfg_start  input  1  begin (or restart) a table load
cfg_abort  input  1  abandon the load in progress
cfg_valid  input  1  cfg_bit is valid
cfg_bit  input  1  serial table bit
cfg_ready  output  1  block accepts cfg_bit
cfg_done  output  1  one-cycle pulse on commit
table_q  output  DEPTH  active truth table (debug readback)

Behaviour:
- Reset (async assert, sync-safe deassert):
  - active table = INIT; shadow = 0; y = 0; out_valid = 0.
  - cfg_ready = 0; cfg_done = 0; bit counter = 0; state = IDLE.
- Evaluation, 1-cycle latency:
  - At each edge: out_valid <= in_valid.
  - If in_valid: y <= active_table[in_vec], using the active table value held before that edge.
  - If !in_valid: y holds its previous value.
  - Evaluation continues in every FSM state and is never stalled.
- Config FSM states: IDLE, SHIFT, COMMIT.
  - IDLE:
    - cfg_ready = 0.
    - cfg_start -> SHIFT; counter = 0; shadow = 0.
    - cfg_valid is ignored.
  - SHIFT:
    - cfg_ready = 1.
    - A bit is accepted when cfg_valid & cfg_ready.
    - Bits arrive MSB-first: the first accepted bit is entry DEPTH-1, the last is entry 0. Shadow shifts left, new bit enters at bit 0.
    - The counter increments per accepted bit. When the DEPTH-th bit is accepted -> COMMIT.
    - Gaps (cfg_valid = 0) are allowed indefinitely.
  - COMMIT (exactly 1 cycle):
    - cfg_ready = 0; cfg_done = 1.
    - At the end of the cycle: active_table <= shadow; counter = 0; -> IDLE.
- Priority within SHIFT, highest first:
  - cfg_abort -> IDLE; shadow discarded; active table unchanged.
  - cfg_start -> restart: counter = 0, shadow = 0, remain in SHIFT; the bit presented that cycle is dropped.
  - Otherwise, normal bit accept.
- cfg_start/cfg_abort in COMMIT are ignored; the commit always completes.
- cfg_abort in IDLE has no effect.
- Commit/evaluate collision: in_valid during the COMMIT cycle is evaluated with the old table. The first lookup using the new table is in the cycle after COMMIT.
- table_q always reflects the active table, never the shadow.
- Reset mid-load: all load progress is lost, active table returns to INIT, and cfg_done is not pulsed.
- Widths:
  - Counter is clog2(DEPTH)+1 bits and never wraps, since the FSM leaves SHIFT at DEPTH.
  - in_vec is used unsigned as the table index; all DEPTH indices are valid.

Test Plan:
- Reset sweep (N_IN=3, INIT=8'hA2): in_vec 0..7 with in_valid held -> y = 0,1,0,0,0,1,0,1, each one cycle after its input; out_valid high from the cycle after the first input; table_q = 8'hA2.
- Load 8'h69 (bits 0,1,1,0,1,0,0,1, MSB-first, with two idle cfg_valid gaps):
  - cfg_ready high for the whole load;
  - cfg_done pulses once, the cycle after the 8th bit;
  - table_q = 8'h69 afterwards;
  - in_vec = 3 -> y = 1; in_vec = 1 -> y = 0.
- Collision: in_valid = 1, in_vec = 1 during the COMMIT cycle of the 8'h69 load -> y = 1 (old table); in_vec = 1 the next cycle -> y = 0.
- Abort and restart:
  - 4 bits, then cfg_abort -> IDLE, table_q stays 8'hA2, no cfg_done.
  - Separately, cfg_start after 5 bits, then 8 fresh bits of 8'hFF -> table_q = 8'hFF.
- Async reset: assert rst_n = 0 mid-clock during SHIFT after 6 bits -> y = 0, out_valid = 0, cfg_ready = 0 immediately; table_q = 8'hA2; a subsequent full load of 8'h00 works normally.
- Hold/idle: in_valid = 0 for 10 cycles after y = 1 -> y stays 1, out_valid stays 0; cfg_valid pulses in IDLE are ignored (table_q unchanged).
